gt_victim_cache_ctrl: RTL and testbench
=======================================

# gt_victim_cache_ctrl

Parametrised successor of the fetch cache: a direct-mapped byte-fetch cache backed by a fully associative victim buffer, with a valid/ready request port toward the IFU and a handshaked line-fill port toward the memory delay unit. Unlike the previous generation, it has a real miss state machine, reset, configurable geometry, FIFO victim replacement and a hit/victim swap path. It sits between the IFU address counter and the memory model.

## Interface
- ADDR_W, 32, byte address width
- LINE_BYTES, 32, bytes per line (power of two, ≥2)
- SETS, 16, direct-mapped sets (power of two)
- VICTIM_ENTRIES, 4, victim buffer entries (≥1)

- CLK  in  1  clock, all state updates on posedge
- CLEAR  in  1  synchronous active-high reset
- req_valid  in  1  fetch request
- req_ready  out  1  high only in IDLE
- req_addr  in  ADDR_W  byte address
- resp_valid  out  1  one-cycle response pulse, no backpressure
- resp_data  out  8  fetched byte
- resp_hit  out  1  qualifies resp_valid: 1 = DM or victim hit, 0 = filled from memory
- mem_req_valid  out  1  line fill request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W-log2(LINE_BYTES)  line address (req_addr >> log2(LINE_BYTES))
- mem_resp_valid  in  1  fill data valid
- mem_resp_data  in  8*LINE_BYTES  line, byte 0 in bits [7:0]

## Operation
- Address split: offset = low log2(LINE_BYTES) bits, index = next log2(SETS) bits, tag = remainder; victim entries store full line address.
- States: IDLE, LOOKUP, SWAP, MREQ, MWAIT, FILL.
- IDLE: req_ready=1; on req_valid, register address → LOOKUP.
- LOOKUP: DM valid & tag match → resp_valid=1, resp_hit=1, resp_data = selected byte, → IDLE. Else victim match → SWAP. Else → MREQ.
- SWAP: victim line moves into DM set; previous DM line (if valid) takes the vacated victim slot, else the slot is invalidated; resp_valid=1, resp_hit=1 → IDLE. FIFO pointer unchanged.
- MREQ: mem_req_valid=1, mem_req_addr stable until mem_req_ready → MWAIT.
- MWAIT: wait for mem_resp_valid → FILL; mem_resp_valid outside MWAIT ignored.
- FILL: if DM set valid, its line is written into victim slot at FIFO pointer (overwriting oldest when full), pointer increments modulo VICTIM_ENTRIES; fetched line written to DM with valid=1; resp_valid=1, resp_hit=0 → IDLE. Invalid DM line is never pushed to victim.
- Invariant: a line address is never valid in both DM and victim.

## Timing
- Reset (CLEAR sampled high at posedge): state=IDLE, all valid bits 0, FIFO pointer 0, req_ready=1, resp_valid=0, resp_hit=0, resp_data=0, mem_req_valid=0, mem_req_addr=0.
- Accept at edge T. DM hit: resp_valid in cycle T+1. Victim hit: cycle T+2. Miss: mem_req_valid from cycle T+2; mem_resp_valid sampled at edge M → resp_valid in cycle M+1.
- Max throughput: one DM hit per 2 cycles (req_ready low in LOOKUP).
- CLEAR mid-miss: aborts immediately, mem_req_valid drops next cycle, pending fill discarded, no response issued.
- Outputs are registered or decoded from state/registered address only; no combinational path from req_* to resp_*.

## Configuration
- GT_CACHE_VICTIM_EN defined: victim buffer, SWAP state and FIFO pointer present as above.
- Undefined: pure direct-mapped; LOOKUP miss goes straight to MREQ; FILL simply overwrites the DM line; VICTIM_ENTRIES ignored; SWAP unreachable.

## Structure
- Package gt_cache_pkg: state enum, localparam helpers for OFFSET_W/INDEX_W/TAG_W derived from parameters, line-address width function.
- One sub-module gt_victim_buffer: fully associative storage, match/lookup by line address, FIFO-pointer insert, slot replace/invalidate for swap.

## Test plan
- Reset then req_addr=0x40 → miss: mem_req_addr=0x2, fill with byte k = k+0x10 → resp_data=0x10, resp_hit=0.
- Repeat req_addr=0x45 → resp_valid one cycle after accept, resp_data=0x15, resp_hit=1, no mem_req_valid.
- Fill 0x40 then conflicting 0x240 (SETS=16) → 0x40 line evicted to victim; req 0x41 → victim hit, resp at T+2, resp_hit=1, no memory traffic; 0x240 now in victim.
- Five conflicting misses into one set with VICTIM_ENTRIES=4 → oldest evicted line lost; re-request misses to memory.
- Assert CLEAR during MWAIT, then mem_resp_valid → no resp_valid, req_ready=1, following req to same address misses.
- mem_req_ready held low 10 cycles → mem_req_valid and mem_req_addr stay stable throughout.

Source files
------------

// File: rtl/gt_cache_pkg.sv
// gt_cache_pkg: shared types and geometry helpers for the victim-backed fetch
// cache.
//   state_t       : miss state machine encoding (also exported as dbg_state)
//   offset_w()    : byte-offset field width for a given line size
//   index_w()     : direct-mapped index field width for a given set count
//   tag_w()       : tag width left over after offset and index
//   line_addr_w() : width of a line address (byte address >> offset_w)
//   slot_w()      : victim slot index width (at least 1 bit)
package gt_cache_pkg;

   localparam int DEF_ADDR_W         = 32;
   localparam int DEF_LINE_BYTES     = 32;
   localparam int DEF_SETS           = 16;
   localparam int DEF_VICTIM_ENTRIES = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_SWAP,
      S_MREQ,
      S_MWAIT,
      S_FILL
   } state_t;

   function automatic int offset_w(input int line_bytes);
      return $clog2(line_bytes);
   endfunction

   function automatic int index_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int addr_w, input int line_bytes, input int sets);
      return addr_w - $clog2(line_bytes) - $clog2(sets);
   endfunction

   function automatic int line_addr_w(input int addr_w, input int line_bytes);
      return addr_w - $clog2(line_bytes);
   endfunction

   function automatic int slot_w(input int entries);
      return (entries > 1) ? $clog2(entries) : 1;
   endfunction

endpackage

// File: rtl/gt_victim_cache_ctrl_if.sv
// gt_victim_cache_ctrl_if: request/response port toward the IFU and line-fill
// port toward the memory delay unit.
//   req_valid/req_ready/req_addr      : fetch request (IFU -> cache)
//   resp_valid/resp_data/resp_hit     : one-cycle response pulse (cache -> IFU)
//   mem_req_valid/mem_req_ready/
//   mem_req_addr                      : line fill request (cache -> memory)
//   mem_resp_valid/mem_resp_data      : fill data, byte 0 in bits [7:0]
// Modports: slave = cache side, master = IFU + memory side.
interface gt_victim_cache_ctrl_if import gt_cache_pkg::*; #(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int LINE_BYTES = DEF_LINE_BYTES
) ();
   localparam int LINE_AW = line_addr_w(ADDR_W, LINE_BYTES);

   logic                    req_valid;
   logic                    req_ready;
   logic [ADDR_W-1:0]       req_addr;
   logic                    resp_valid;
   logic [7:0]              resp_data;
   logic                    resp_hit;
   logic                    mem_req_valid;
   logic                    mem_req_ready;
   logic [LINE_AW-1:0]      mem_req_addr;
   logic                    mem_resp_valid;
   logic [8*LINE_BYTES-1:0] mem_resp_data;

   modport slave (
      input  req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
      output req_ready, resp_valid, resp_data, resp_hit, mem_req_valid, mem_req_addr
   );

   modport master (
      output req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
      input  req_ready, resp_valid, resp_data, resp_hit, mem_req_valid, mem_req_addr
   );
endinterface

// File: rtl/gt_victim_buffer.sv
// gt_victim_buffer: fully associative store of lines evicted from the
// direct-mapped array.
//   clk, clear         : clock, synchronous active-high reset (clears valids, pointer)
//   lookup_addr        : line address to match
//   hit/hit_slot/
//   hit_data           : match result (at most one slot matches)
//   insert_*           : write a line at the FIFO pointer, then advance it
//   swap_*             : rewrite one slot with the displaced DM line, or
//                        invalidate it when the DM set was empty; the FIFO
//                        pointer is left alone
module gt_victim_buffer #(
   parameter int LINE_AW = 27,
   parameter int LINE_W  = 256,
   parameter int ENTRIES = 4,
   parameter int SLOT_W  = 2
) (
   input  logic               clk,
   input  logic               clear,
   input  logic [LINE_AW-1:0] lookup_addr,
   output logic               hit,
   output logic [SLOT_W-1:0]  hit_slot,
   output logic [LINE_W-1:0]  hit_data,
   input  logic               insert_en,
   input  logic [LINE_AW-1:0] insert_addr,
   input  logic [LINE_W-1:0]  insert_data,
   input  logic               swap_en,
   input  logic [SLOT_W-1:0]  swap_slot,
   input  logic               swap_valid,
   input  logic [LINE_AW-1:0] swap_addr,
   input  logic [LINE_W-1:0]  swap_data
);
   logic [ENTRIES-1:0] valid;
   logic [LINE_AW-1:0] addr [ENTRIES];
   logic [LINE_W-1:0]  data [ENTRIES];
   logic [SLOT_W-1:0]  ptr;

   always_comb begin
      hit      = 1'b0;
      hit_slot = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid[i] && (addr[i] == lookup_addr)) begin
            hit      = 1'b1;
            hit_slot = SLOT_W'(i);
         end
      end
   end

   assign hit_data = data[hit_slot];

   always_ff @(posedge clk) begin
      if (clear) begin
         valid <= '0;
         ptr   <= '0;
      end else begin
         if (insert_en) begin
            valid[ptr] <= 1'b1;
            addr[ptr]  <= insert_addr;
            data[ptr]  <= insert_data;
            ptr        <= (ptr == SLOT_W'(ENTRIES - 1)) ? '0 : ptr + SLOT_W'(1);
         end
         if (swap_en) begin
            valid[swap_slot] <= swap_valid;
            if (swap_valid) begin
               addr[swap_slot] <= swap_addr;
               data[swap_slot] <= swap_data;
            end
         end
      end
   end
endmodule

// File: rtl/gt_victim_cache_ctrl.sv
// gt_victim_cache_ctrl: direct-mapped byte-fetch cache with an optional fully
// associative victim buffer, between the IFU address counter and memory.
//   CLK, CLEAR : clock, synchronous active-high reset
//   bus        : gt_victim_cache_ctrl_if.slave (IFU request/response, line fill)
//   dbg_state  : current miss state machine state
// Build option GT_CACHE_VICTIM_EN: when defined, the victim buffer, SWAP state
// and FIFO pointer are present; otherwise the cache is purely direct-mapped.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is high only in IDLE; mem_req_valid is held, with
// mem_req_addr stable, until mem_req_ready. resp_valid and mem_resp_valid are
// single-cycle pulses with no backpressure.
module gt_victim_cache_ctrl import gt_cache_pkg::*; #(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int LINE_BYTES     = DEF_LINE_BYTES,
   parameter int SETS           = DEF_SETS,
   parameter int VICTIM_ENTRIES = DEF_VICTIM_ENTRIES
) (
   input  logic                    CLK,
   input  logic                    CLEAR,
   gt_victim_cache_ctrl_if.slave   bus,
   output state_t                  dbg_state
);
   localparam int OFFSET_W = offset_w(LINE_BYTES);
   localparam int INDEX_W  = index_w(SETS);
   localparam int TAG_W    = tag_w(ADDR_W, LINE_BYTES, SETS);
   localparam int LINE_AW  = line_addr_w(ADDR_W, LINE_BYTES);
   localparam int LINE_W   = 8 * LINE_BYTES;

   if (LINE_BYTES < 2 || VICTIM_ENTRIES < 1) begin : g_bad_cfg
      $error("gt_victim_cache_ctrl: LINE_BYTES must be >= 2 and VICTIM_ENTRIES >= 1");
   end

   state_t              state;
   logic [ADDR_W-1:0]   addr_q;
   logic [LINE_AW-1:0]  mem_req_addr_q;
   logic [LINE_W-1:0]   fill_q;
   logic [SETS-1:0]     dm_valid;
   logic [TAG_W-1:0]    dm_tag  [SETS];
   logic [LINE_W-1:0]   dm_data [SETS];

   // Address fields of the request being served.
   logic [OFFSET_W-1:0] offset;
   logic [INDEX_W-1:0]  index;
   logic [TAG_W-1:0]    tag;
   logic [LINE_AW-1:0]  line_addr;
   assign offset    = addr_q[OFFSET_W-1:0];
   assign index     = addr_q[OFFSET_W +: INDEX_W];
   assign tag       = addr_q[ADDR_W-1 -: TAG_W];
   assign line_addr = addr_q[ADDR_W-1:OFFSET_W];

   logic               dm_hit;
   logic [LINE_W-1:0]  dm_line;
   assign dm_hit  = dm_valid[index] && (dm_tag[index] == tag);
   assign dm_line = dm_data[index];

   logic               vb_hit;
   logic [LINE_W-1:0]  vb_data;

`ifdef GT_CACHE_VICTIM_EN
   localparam int SLOT_W = slot_w(VICTIM_ENTRIES);

   logic [SLOT_W-1:0]  vb_slot;
   logic [LINE_AW-1:0] dm_line_addr;
   assign dm_line_addr = {dm_tag[index], index};

   // The lookup address is held through SWAP and the buffer does not change
   // between LOOKUP and SWAP, so the match stays valid for the swap itself.
   gt_victim_buffer #(
      .LINE_AW (LINE_AW),
      .LINE_W  (LINE_W),
      .ENTRIES (VICTIM_ENTRIES),
      .SLOT_W  (SLOT_W)
   ) u_victim_buffer (
      .clk         (CLK),
      .clear       (CLEAR),
      .lookup_addr (line_addr),
      .hit         (vb_hit),
      .hit_slot    (vb_slot),
      .hit_data    (vb_data),
      .insert_en   ((state == S_FILL) && dm_valid[index]),
      .insert_addr (dm_line_addr),
      .insert_data (dm_line),
      .swap_en     (state == S_SWAP),
      .swap_slot   (vb_slot),
      .swap_valid  (dm_valid[index]),
      .swap_addr   (dm_line_addr),
      .swap_data   (dm_line)
   );
`else
   assign vb_hit  = 1'b0;
   assign vb_data = '0;
`endif

   always_ff @(posedge CLK) begin
      if (CLEAR) begin
         state          <= S_IDLE;
         addr_q         <= '0;
         mem_req_addr_q <= '0;
         fill_q         <= '0;
         dm_valid       <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  addr_q <= bus.req_addr;
                  state  <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (dm_hit) begin
                  state <= S_IDLE;
               end else if (vb_hit) begin
                  state <= S_SWAP;
               end else begin
                  mem_req_addr_q <= line_addr;
                  state          <= S_MREQ;
               end
            end
            S_SWAP: begin
               dm_valid[index] <= 1'b1;
               dm_tag[index]   <= tag;
               dm_data[index]  <= vb_data;
               state           <= S_IDLE;
            end
            S_MREQ: begin
               if (bus.mem_req_ready) state <= S_MWAIT;
            end
            S_MWAIT: begin
               if (bus.mem_resp_valid) begin
                  fill_q <= bus.mem_resp_data;
                  state  <= S_FILL;
               end
            end
            S_FILL: begin
               dm_valid[index] <= 1'b1;
               dm_tag[index]   <= tag;
               dm_data[index]  <= fill_q;
               state           <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Responses are decoded from state and registered storage only, so there is
   // no combinational path from req_* to resp_*.
   logic              resp_valid;
   logic              resp_hit;
   logic [LINE_W-1:0] sel_line;

   always_comb begin
      resp_valid = 1'b0;
      resp_hit   = 1'b0;
      sel_line   = dm_line;
      unique case (state)
         S_LOOKUP: begin
            resp_valid = dm_hit;
            resp_hit   = dm_hit;
         end
         S_SWAP: begin
            resp_valid = 1'b1;
            resp_hit   = 1'b1;
            sel_line   = vb_data;
         end
         S_FILL: begin
            resp_valid = 1'b1;
            sel_line   = fill_q;
         end
         default: ;
      endcase
   end

   assign bus.req_ready     = (state == S_IDLE);
   assign bus.resp_valid    = resp_valid;
   assign bus.resp_hit      = resp_hit;
   assign bus.resp_data     = resp_valid ? sel_line[{offset, 3'b000} +: 8] : 8'h00;
   assign bus.mem_req_valid = (state == S_MREQ);
   assign bus.mem_req_addr  = mem_req_addr_q;
   assign dbg_state         = state;
endmodule

// File: tb/tb_gt_victim_cache_ctrl.sv
// tb_gt_victim_cache_ctrl: directed bench for gt_victim_cache_ctrl with the
// default geometry (32-bit address, 32-byte lines, 16 sets, 4 victim slots).
// Expectations follow GT_CACHE_VICTIM_EN: victim hits where it is defined,
// refills from memory where it is not.
module tb_gt_victim_cache_ctrl;
   import gt_cache_pkg::*;

   localparam int ADDR_W         = 32;
   localparam int LINE_BYTES     = 32;
   localparam int SETS           = 16;
   localparam int VICTIM_ENTRIES = 4;
   localparam int LINE_W         = 8 * LINE_BYTES;
   localparam int LINE_AW        = ADDR_W - 5;
`ifdef GT_CACHE_VICTIM_EN
   localparam bit VEN = 1'b1;
`else
   localparam bit VEN = 1'b0;
`endif

   logic   clk;
   logic   clear;
   state_t dbg_state;
   int     checks   = 0;
   int     failures = 0;
   logic [7:0] exp_q[$];

   gt_victim_cache_ctrl_if #(.ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES)) bus ();

   gt_victim_cache_ctrl #(
      .ADDR_W         (ADDR_W),
      .LINE_BYTES     (LINE_BYTES),
      .SETS           (SETS),
      .VICTIM_ENTRIES (VICTIM_ENTRIES)
   ) dut (
      .CLK       (clk),
      .CLEAR     (clear),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   function automatic logic [LINE_W-1:0] make_line(input logic [7:0] base);
      logic [LINE_W-1:0] l;
      for (int k = 0; k < LINE_BYTES; k++) l[k*8 +: 8] = base + 8'(k);
      return l;
   endfunction

   // One fetch, called #1 after a rising edge with the cache idle. Memory is
   // served in-line: mem_req_ready is held low for 'stall' cycles of
   // mem_req_valid, then one handshake, then fill data one cycle later.
   // Latency is counted in cycles after the accept edge.
   task automatic access(input string name, input logic [ADDR_W-1:0] addr,
                         input logic [7:0] base, input logic exp_hit,
                         input int exp_lat, input int exp_mem, input int stall);
      int cyc, lat, mem_reqs, stall_left;
      bit done;
      logic [7:0] data, exp_data;
      logic hit;
      logic [LINE_AW-1:0] exp_line;
      exp_line = addr[ADDR_W-1:5];
      exp_data = exp_q.pop_front();
      check({name, "_ready"}, 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      cyc = 0; lat = 0; done = 1'b0; mem_reqs = 0; stall_left = stall;
      data = '0; hit = 1'b0;
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) check({name, "_lookup_busy"}, 64'(bus.req_ready), 64'd0);
         if (bus.resp_valid) begin
            done = 1'b1;
            lat  = cyc;
            data = bus.resp_data;
            hit  = bus.resp_hit;
         end else if (bus.mem_req_valid) begin
            check({name, "_mem_addr"}, 64'(bus.mem_req_addr), 64'(exp_line));
            if (stall_left > 0) begin
               stall_left--;
            end else begin
               mem_reqs++;
               bus.mem_req_ready = 1'b1;
               @(posedge clk); #1;
               bus.mem_req_ready  = 1'b0;
               bus.mem_resp_valid = 1'b1;
               bus.mem_resp_data  = make_line(base);
               @(posedge clk); #1;
               bus.mem_resp_valid = 1'b0;
               bus.mem_resp_data  = '0;
               cyc += 2;
            end
         end
      end
      check({name, "_responded"}, 64'(done), 64'd1);
      check({name, "_data"}, 64'(data), 64'(exp_data));
      check({name, "_hit"}, 64'(hit), 64'(exp_hit));
      check({name, "_latency"}, 64'(lat), 64'(exp_lat));
      check({name, "_mem_reqs"}, 64'(mem_reqs), 64'(exp_mem));
      @(posedge clk); #1;
   endtask

   initial begin
      int  cnt;
      bit  resp_seen;
      clear              = 1'b1;
      bus.req_valid      = 1'b0;
      bus.req_addr       = '0;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      clear = 1'b0;

      // Reset state
      check("rst_state", 64'(dbg_state), 64'(S_IDLE));
      check("rst_req_ready", 64'(bus.req_ready), 64'd1);
      check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      check("rst_resp_hit", 64'(bus.resp_hit), 64'd0);
      check("rst_resp_data", 64'(bus.resp_data), 64'd0);
      check("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
      check("rst_mem_req_addr", 64'(bus.mem_req_addr), 64'd0);

      // Cold miss, then DM hit in the same line
      exp_q.push_back(8'h10); access("miss_40", 32'h40, 8'h10, 1'b0, 5, 1, 0);
      exp_q.push_back(8'h15); access("hit_45", 32'h45, 8'h00, 1'b1, 1, 0, 0);

      // Conflict in set 2 evicts 0x40; fetches bounce between DM and victim
      exp_q.push_back(8'h20); access("miss_240", 32'h240, 8'h20, 1'b0, 5, 1, 0);
      exp_q.push_back(8'h11);
      access("vict_41", 32'h41, 8'h10, VEN, VEN ? 2 : 5, VEN ? 0 : 1, 0);
      exp_q.push_back(8'h3f);
      access("vict_25f", 32'h25f, 8'h20, VEN, VEN ? 2 : 5, VEN ? 0 : 1, 0);

      // Five more conflicting misses overflow the 4-entry victim FIFO
      exp_q.push_back(8'h30); access("miss_440", 32'h440, 8'h30, 1'b0, 5, 1, 0);
      exp_q.push_back(8'h40); access("miss_640", 32'h640, 8'h40, 1'b0, 5, 1, 0);
      exp_q.push_back(8'h50); access("miss_840", 32'h840, 8'h50, 1'b0, 5, 1, 0);
      exp_q.push_back(8'h60); access("miss_a40", 32'ha40, 8'h60, 1'b0, 5, 1, 0);
      exp_q.push_back(8'h70); access("miss_c40", 32'hc40, 8'h70, 1'b0, 5, 1, 0);
      // Oldest evicted line (0x40) is gone; 0x640 is still held
      exp_q.push_back(8'h10); access("lost_40", 32'h40, 8'h10, 1'b0, 5, 1, 0);
      exp_q.push_back(8'h46);
      access("kept_646", 32'h646, 8'h40, VEN, VEN ? 2 : 5, VEN ? 0 : 1, 0);

      // Memory stalls the request for 10 cycles
      exp_q.push_back(8'h80); access("stall_1000", 32'h1000, 8'h80, 1'b0, 15, 1, 10);
      exp_q.push_back(8'h9f); access("hit_101f", 32'h101f, 8'h00, 1'b1, 1, 0, 0);

      // CLEAR while waiting for fill data
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h80;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      cnt = 0;
      while (!bus.mem_req_valid && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      check("clr_mem_req_seen", 64'(bus.mem_req_valid), 64'd1);
      bus.mem_req_ready = 1'b1;
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b0;
      check("clr_in_mwait", 64'(dbg_state), 64'(S_MWAIT));
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = make_line(8'h55);
      @(posedge clk); #1;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = '0;
      resp_seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.resp_valid) resp_seen = 1'b1;
      end
      check("clr_no_resp", 64'(resp_seen), 64'd0);
      check("clr_req_ready", 64'(bus.req_ready), 64'd1);
      check("clr_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
      @(posedge clk); #1;
      exp_q.push_back(8'h90); access("after_clr_80", 32'h80, 8'h90, 1'b0, 5, 1, 0);
      exp_q.push_back(8'h84); access("after_clr_1004", 32'h1004, 8'h80, 1'b0, 5, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
